// File: rtl/iob_native_bridge.sv
// -----------------------------------------------------------------------------
// iob_native_bridge
//
// Bridges a native valid/ready CPU memory port onto N_SLAVES independent
// IOb-style request/response ports. The request is registered, and a 4-state
// FSM (IDLE -> REQ -> RESP -> DONE) keeps at most one transaction in flight.
// The target slave is chosen from the top SEL_W address bits. When
// I_SLAVE >= 0, instruction fetches are forced to that slave instead.
//
// Optional feature macro: IOB_NATIVE_BRIDGE_TIMEOUT_EN
//   When this macro is defined, a TIMEOUT_W-bit watchdog aborts stalled
//   accesses with an error and marks the slave dead until reset. Later
//   accesses to a dead slave complete with an error and no bus request.
//   When it is undefined, the bridge waits indefinitely for a slave.
//
// Ports
//   clk, rst         clock, asynchronous active-high reset
//   cpu_valid        native request valid, held until cpu_ready
//   cpu_instr        request is an instruction fetch
//   cpu_addr         byte address
//   cpu_wdata        write data
//   cpu_wstrb        byte strobes; all zero means read
//   cpu_rdata        read data, valid while cpu_ready=1, held otherwise
//   cpu_ready        single-cycle completion pulse
//   err              single-cycle pulse on an error/aborted completion
//   m_avalid         per-slave request valid (one-hot or zero)
//   m_addr           registered address, shared by all slaves
//   m_wdata          registered write data, shared by all slaves
//   m_wstrb          registered strobes, shared by all slaves
//   m_ready          per-slave request accept
//   m_rvalid         per-slave response valid (reads and writes)
//   m_rdata          per-slave read data, slave k at [k*DATA_W +: DATA_W]
// -----------------------------------------------------------------------------
module iob_native_bridge #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int N_SLAVES  = 2,
  parameter int SEL_W     = 1,
  parameter int I_SLAVE   = -1,
  parameter int TIMEOUT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_valid,
  input  logic                       cpu_instr,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic [DATA_W/8-1:0]        cpu_wstrb,
  output logic [DATA_W-1:0]          cpu_rdata,
  output logic                       cpu_ready,
  output logic                       err,
  output logic [N_SLAVES-1:0]        m_avalid,
  output logic [ADDR_W-1:0]          m_addr,
  output logic [DATA_W-1:0]          m_wdata,
  output logic [DATA_W/8-1:0]        m_wstrb,
  input  logic [N_SLAVES-1:0]        m_ready,
  input  logic [N_SLAVES-1:0]        m_rvalid,
  input  logic [N_SLAVES*DATA_W-1:0] m_rdata
);

  localparam int STRB_W = DATA_W / 8;
  localparam bit I_EN = (I_SLAVE >= 0);
  localparam logic [SEL_W-1:0] I_IDX = I_EN ? SEL_W'(I_SLAVE) : '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // One-hot decode of a slave index; indices >= N_SLAVES decode to all zeros,
  // which doubles as the out-of-range indication.
  function automatic logic [N_SLAVES-1:0] decode_sel(input logic [SEL_W-1:0] sel);
    logic [N_SLAVES-1:0] oh;
    oh = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      oh[k] = (sel == SEL_W'(k));
    end
    return oh;
  endfunction

  state_t              state_q, state_d;
  logic [N_SLAVES-1:0] sel_oh_q, sel_oh_d;
  logic [N_SLAVES-1:0] m_avalid_q, m_avalid_d;
  logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic                err_q, err_d;

  logic [SEL_W-1:0]    req_sel_s;
  logic [N_SLAVES-1:0] req_oh_s;
  logic                ready_sel_s;
  logic                rvalid_sel_s;
  logic [DATA_W-1:0]   rdata_sel_s;
  logic                timeout_s;
  logic                blocked_s;

  // Slave index of the incoming CPU request (instruction override or address MSBs).
  always_comb begin
    if (I_EN && cpu_instr) begin
      req_sel_s = I_IDX;
    end else begin
      req_sel_s = cpu_addr[ADDR_W-1 -: SEL_W];
    end
    req_oh_s = decode_sel(req_sel_s);
  end

  // Pick out the selected slave's handshake and data; other slaves are ignored.
  always_comb begin
    ready_sel_s  = |(m_ready & sel_oh_q);
    rvalid_sel_s = |(m_rvalid & sel_oh_q);
    rdata_sel_s  = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      rdata_sel_s = rdata_sel_s | (m_rdata[k*DATA_W +: DATA_W] & {DATA_W{sel_oh_q[k]}});
    end
  end

`ifdef IOB_NATIVE_BRIDGE_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [N_SLAVES-1:0]  dead_q, dead_d;

  // Watchdog count: zero outside REQ/RESP, so it is clear on every REQ entry.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_s = 1'b0;
    if ((state_q == ST_REQ) || (state_q == ST_RESP)) begin
      cnt_d     = cnt_q + TIMEOUT_W'(1);
      timeout_s = (cnt_d == {TIMEOUT_W{1'b1}});
    end else begin
      cnt_d = '0;
    end
    blocked_s = |(dead_q & req_oh_s);
  end

  // A slave becomes dead when its access leaves REQ/RESP with an error,
  // which in those states can only be a watchdog abort.
  always_comb begin
    if (((state_q == ST_REQ) || (state_q == ST_RESP)) && (state_d == ST_DONE) && err_d) begin
      dead_d = dead_q | sel_oh_q;
    end else begin
      dead_d = dead_q;
    end
  end

  // Watchdog counter and dead-slave mask; only rst clears the mask.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      dead_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      dead_q <= dead_d;
    end
  end
`else
  assign timeout_s = 1'b0;
  assign blocked_s = 1'b0;

  // TIMEOUT_W only sizes the watchdog; it stays in the parameter list so both
  // builds share one interface.
  if (TIMEOUT_W < 1) begin : g_timeout_w_unused
  end
`endif

  // FSM next state, request capture and completion outputs.
  always_comb begin
    state_d     = state_q;
    sel_oh_d    = sel_oh_q;
    m_avalid_d  = '0;
    m_addr_d    = m_addr_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cpu_valid) begin
          m_addr_d  = cpu_addr;
          m_wdata_d = cpu_wdata;
          m_wstrb_d = cpu_wstrb;
          sel_oh_d  = req_oh_s;
          if ((req_oh_s == '0) || blocked_s) begin
            // Unmapped or dead slave: complete with error, no bus request.
            state_d     = ST_DONE;
            cpu_ready_d = 1'b1;
            err_d       = 1'b1;
            cpu_rdata_d = '0;
          end else begin
            state_d    = ST_REQ;
            m_avalid_d = req_oh_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (ready_sel_s && rvalid_sel_s) begin
          state_d     = ST_DONE;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = rdata_sel_s;
        end else if (timeout_s) begin
          // Watchdog wins over a bare accept so the count cannot wrap in RESP.
          state_d     = ST_DONE;
          cpu_ready_d = 1'b1;
          err_d       = 1'b1;
          cpu_rdata_d = '0;
        end else if (ready_sel_s) begin
          state_d = ST_RESP;
        end else begin
          state_d    = ST_REQ;
          m_avalid_d = sel_oh_q;
        end
      end

      ST_RESP: begin
        if (rvalid_sel_s) begin
          state_d     = ST_DONE;
          cpu_ready_d = 1'b1;
          cpu_rdata_d = rdata_sel_s;
        end else if (timeout_s) begin
          state_d     = ST_DONE;
          cpu_ready_d = 1'b1;
          err_d       = 1'b1;
          cpu_rdata_d = '0;
        end else begin
          state_d = ST_RESP;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_oh_q    <= '0;
      m_avalid_q  <= '0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_oh_q    <= sel_oh_d;
      m_avalid_q  <= m_avalid_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      err_q       <= err_d;
    end
  end

  assign m_avalid  = m_avalid_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign err       = err_q;

endmodule

// File: tb/tb_iob_native_bridge.sv
// -----------------------------------------------------------------------------
// tb_iob_native_bridge
//
// Directed bench for iob_native_bridge with 3 slaves decoded by the top 2
// address bits and instruction fetches forced to slave 0. Cycle n is the
// interval after the n-th rising edge counted from the request's cycle 0;
// inputs are driven and outputs sampled 1 time unit after the rising edge.
// With IOB_NATIVE_BRIDGE_TIMEOUT_EN defined, the watchdog is also exercised
// using TIMEOUT_W=4.
// -----------------------------------------------------------------------------
module tb_iob_native_bridge;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int N_SLAVES = 3;
  localparam int SEL_W    = 2;
  localparam int I_SLAVE  = 0;
`ifdef IOB_NATIVE_BRIDGE_TIMEOUT_EN
  localparam int TIMEOUT_W = 4;
`else
  localparam int TIMEOUT_W = 8;
`endif

  logic                       clk;
  logic                       rst;
  logic                       cpu_valid;
  logic                       cpu_instr;
  logic [ADDR_W-1:0]          cpu_addr;
  logic [DATA_W-1:0]          cpu_wdata;
  logic [DATA_W/8-1:0]        cpu_wstrb;
  logic [DATA_W-1:0]          cpu_rdata;
  logic                       cpu_ready;
  logic                       err;
  logic [N_SLAVES-1:0]        m_avalid;
  logic [ADDR_W-1:0]          m_addr;
  logic [DATA_W-1:0]          m_wdata;
  logic [DATA_W/8-1:0]        m_wstrb;
  logic [N_SLAVES-1:0]        m_ready;
  logic [N_SLAVES-1:0]        m_rvalid;
  logic [N_SLAVES*DATA_W-1:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  iob_native_bridge #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .N_SLAVES (N_SLAVES),
    .SEL_W    (SEL_W),
    .I_SLAVE  (I_SLAVE),
    .TIMEOUT_W(TIMEOUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_valid(cpu_valid),
    .cpu_instr(cpu_instr),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .err      (err),
    .m_avalid (m_avalid),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_wstrb  (m_wstrb),
    .m_ready  (m_ready),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    m_ready  = 3'b000;
    m_rvalid = 3'b000;
  endtask

  task automatic cpu_req(input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    cpu_valid = 1'b1;
    cpu_instr = instr;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_wstrb = wstrb;
  endtask

  // Directed stimulus and checks.
  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    cpu_valid = 1'b0;
    cpu_instr = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_wstrb = 4'h0;
    m_ready   = 3'b000;
    m_rvalid  = 3'b010;
    m_rdata   = {32'h2222_2222, 32'hCAFE_BABE, 32'h1111_1111};

    // Reset state
    tick();
    tick();
    check_eq("rst_avalid", m_avalid, 64'h0);
    check_eq("rst_addr", m_addr, 64'h0);
    check_eq("rst_wdata", m_wdata, 64'h0);
    check_eq("rst_wstrb", m_wstrb, 64'h0);
    check_eq("rst_ready", cpu_ready, 64'h0);
    check_eq("rst_rdata", cpu_rdata, 64'h0);
    check_eq("rst_err", err, 64'h0);
    rst = 1'b0;
    idle_bus();
    tick();

    // Read from slave 1, minimum latency; other slaves' handshakes also high
    cpu_req(1'b0, 32'h4000_0010, 32'h0, 4'h0);
    check_eq("rd_c0_avalid", m_avalid, 64'h0);
    tick();
    check_eq("rd_c1_avalid", m_avalid, 64'h2);
    check_eq("rd_c1_addr", m_addr, 64'h4000_0010);
    m_ready  = 3'b111;
    m_rvalid = 3'b111;
    tick();
    check_eq("rd_c2_ready", cpu_ready, 64'h1);
    check_eq("rd_c2_rdata", cpu_rdata, 64'hCAFE_BABE);
    check_eq("rd_c2_err", err, 64'h0);
    check_eq("rd_c2_avalid", m_avalid, 64'h0);
    cpu_valid = 1'b0;
    idle_bus();
    tick();
    check_eq("rd_c3_ready", cpu_ready, 64'h0);
    check_eq("rd_c3_rdata_hold", cpu_rdata, 64'hCAFE_BABE);

    // Write to slave 0: accept at cycle 3, response at cycle 6
    cpu_req(1'b0, 32'h0000_0004, 32'h1234_5678, 4'b0011);
    m_rvalid = 3'b010;
    tick();
    check_eq("wr_c1_avalid", m_avalid, 64'h1);
    check_eq("wr_c1_wstrb", m_wstrb, 64'h3);
    check_eq("wr_c1_wdata", m_wdata, 64'h1234_5678);
    tick();
    check_eq("wr_c2_avalid", m_avalid, 64'h1);
    tick();
    check_eq("wr_c3_avalid", m_avalid, 64'h1);
    m_ready = 3'b001;
    tick();
    check_eq("wr_c4_avalid", m_avalid, 64'h0);
    check_eq("wr_c4_wstrb", m_wstrb, 64'h3);
    m_ready = 3'b000;
    tick();
    check_eq("wr_c5_ready", cpu_ready, 64'h0);
    tick();
    check_eq("wr_c6_wstrb", m_wstrb, 64'h3);
    check_eq("wr_c6_ready", cpu_ready, 64'h0);
    m_rvalid = 3'b001;
    tick();
    check_eq("wr_c7_ready", cpu_ready, 64'h1);
    check_eq("wr_c7_err", err, 64'h0);
    check_eq("wr_c7_wstrb", m_wstrb, 64'h3);
    check_eq("wr_c7_addr", m_addr, 64'h4);
    cpu_valid = 1'b0;
    idle_bus();
    tick();

    // Instruction fetch forced to slave 0, then the same address as data, back-to-back
    cpu_req(1'b1, 32'h4000_0000, 32'h0, 4'h0);
    m_ready  = 3'b001;
    m_rvalid = 3'b001;
    tick();
    check_eq("if_c1_avalid", m_avalid, 64'h1);
    tick();
    check_eq("if_c2_ready", cpu_ready, 64'h1);
    check_eq("if_c2_rdata", cpu_rdata, 64'h1111_1111);
    cpu_instr = 1'b0;
    idle_bus();
    tick();
    check_eq("b2b_c3_avalid", m_avalid, 64'h0);
    check_eq("b2b_c3_ready", cpu_ready, 64'h0);
    tick();
    check_eq("b2b_c4_avalid", m_avalid, 64'h2);
    m_ready  = 3'b010;
    m_rvalid = 3'b010;
    tick();
    check_eq("b2b_c5_ready", cpu_ready, 64'h1);
    check_eq("b2b_c5_rdata", cpu_rdata, 64'hCAFE_BABE);
    cpu_valid = 1'b0;
    idle_bus();
    tick();

    // Reset while waiting in RESP, then a fresh access to slave 2
    cpu_req(1'b0, 32'h4000_0010, 32'h0, 4'h0);
    tick();
    m_ready = 3'b010;
    tick();
    check_eq("rr_c2_avalid", m_avalid, 64'h0);
    check_eq("rr_c2_ready", cpu_ready, 64'h0);
    idle_bus();
    m_rvalid  = 3'b010;
    rst       = 1'b1;
    cpu_valid = 1'b0;
    #1;
    check_eq("rr_rst_addr", m_addr, 64'h0);
    check_eq("rr_rst_rdata", cpu_rdata, 64'h0);
    tick();
    tick();
    check_eq("rr_rst_ready", cpu_ready, 64'h0);
    check_eq("rr_rst_avalid", m_avalid, 64'h0);
    rst = 1'b0;
    idle_bus();
    cpu_req(1'b0, 32'h8000_0000, 32'h0, 4'h0);
    tick();
    check_eq("rr_new_c1_avalid", m_avalid, 64'h4);
    m_ready  = 3'b100;
    m_rvalid = 3'b100;
    tick();
    check_eq("rr_new_c2_ready", cpu_ready, 64'h1);
    check_eq("rr_new_c2_rdata", cpu_rdata, 64'h2222_2222);
    cpu_valid = 1'b0;
    idle_bus();
    tick();

    // Out-of-range decode (index 3 with 3 slaves); responses in IDLE ignored
    cpu_req(1'b0, 32'hC000_0000, 32'hDEAD_BEEF, 4'hF);
    m_ready  = 3'b111;
    m_rvalid = 3'b111;
    tick();
    check_eq("oor_c1_ready", cpu_ready, 64'h1);
    check_eq("oor_c1_err", err, 64'h1);
    check_eq("oor_c1_rdata", cpu_rdata, 64'h0);
    check_eq("oor_c1_avalid", m_avalid, 64'h0);
    cpu_valid = 1'b0;
    idle_bus();
    tick();
    check_eq("oor_c2_ready", cpu_ready, 64'h0);
    check_eq("oor_c2_err", err, 64'h0);
    check_eq("oor_c2_avalid", m_avalid, 64'h0);

`ifdef IOB_NATIVE_BRIDGE_TIMEOUT_EN
    // Slave 1 never answers: error completion 15 cycles after REQ entry
    cpu_req(1'b0, 32'h4000_0010, 32'h0, 4'h0);
    tick();
    check_eq("to_c1_avalid", m_avalid, 64'h2);
    repeat (13) tick();
    tick();
    check_eq("to_c15_ready", cpu_ready, 64'h0);
    check_eq("to_c15_avalid", m_avalid, 64'h2);
    tick();
    check_eq("to_c16_ready", cpu_ready, 64'h1);
    check_eq("to_c16_err", err, 64'h1);
    check_eq("to_c16_rdata", cpu_rdata, 64'h0);
    check_eq("to_c16_avalid", m_avalid, 64'h0);
    cpu_valid = 1'b0;
    tick();
    // Dead slave: immediate error, no request
    cpu_req(1'b0, 32'h4000_0010, 32'h0, 4'h0);
    tick();
    check_eq("dead_c1_ready", cpu_ready, 64'h1);
    check_eq("dead_c1_err", err, 64'h1);
    check_eq("dead_c1_avalid", m_avalid, 64'h0);
    cpu_valid = 1'b0;
    tick();
    check_eq("dead_c2_avalid", m_avalid, 64'h0);
    // Reset clears the dead mask
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cpu_req(1'b0, 32'h4000_0010, 32'h0, 4'h0);
    tick();
    check_eq("revive_c1_avalid", m_avalid, 64'h2);
    m_ready  = 3'b010;
    m_rvalid = 3'b010;
    tick();
    check_eq("revive_c2_ready", cpu_ready, 64'h1);
    check_eq("revive_c2_err", err, 64'h0);
    check_eq("revive_c2_rdata", cpu_rdata, 64'hCAFE_BABE);
    cpu_valid = 1'b0;
    idle_bus();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iob_native_bridge.md
# iob_native_bridge

Parametrised successor to the CPU-side bus adapter. Converts a native valid/ready memory port into N_SLAVES independent IOb-style request/response ports. A registered request stage and a 4-state FSM replace the old combinational avalid gating, so one transaction is in flight at a time. The target slave is chosen by address decode, with optional forced routing of instruction fetches. Sits between the CPU core wrapper and the interconnect/memories.

## Interface
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Must be a multiple of 8.
- N_SLAVES, 2: number of slave ports, 1..16.
- SEL_W, 1: number of address MSBs, addr[ADDR_W-1 -: SEL_W], used as the slave index. Must satisfy 2^SEL_W ≥ N_SLAVES.
- I_SLAVE, -1: when ≥0, all accesses with cpu_instr=1 route to this slave regardless of address. When -1, instruction fetches are decoded by address like data accesses.
- TIMEOUT_W, 8: width of the timeout counter. Used only with IOB_NATIVE_BRIDGE_TIMEOUT_EN.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_valid  in  1  native request valid. Held high until cpu_ready.
- cpu_instr  in  1  access is an instruction fetch.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_wstrb  in  DATA_W/8  byte strobes. All zero means read.
- cpu_rdata  out  DATA_W  read data. Valid only while cpu_ready=1.
- cpu_ready  out  1  single-cycle completion pulse.
- err  out  1  single-cycle pulse on an aborted or error-completed access.
- m_avalid  out  N_SLAVES  per-slave request valid.
- m_addr  out  ADDR_W  registered address, shared by all slaves.
- m_wdata  out  DATA_W  registered write data, shared.
- m_wstrb  out  DATA_W/8  registered strobes, shared.
- m_ready  in  N_SLAVES  per-slave request accept.
- m_rvalid  in  N_SLAVES  per-slave response valid. Also asserted for writes.
- m_rdata  in  N_SLAVES*DATA_W  per-slave read data. Slave k occupies bits [k*DATA_W +: DATA_W].

## Operation
FSM states and transitions:
- **IDLE**
  - On cpu_valid=1, register addr/wdata/wstrb and compute the slave index sel.
  - If sel ≥ N_SLAVES, go to DONE with error.
  - Otherwise go to REQ.
- **REQ**
  - Drive m_avalid[sel]=1. All other m_avalid bits are 0.
  - m_ready[sel]=1 and m_rvalid[sel]=1 in the same cycle: capture rdata, go to DONE.
  - m_ready[sel]=1 alone: go to RESP.
- **RESP**
  - m_avalid=0.
  - On m_rvalid[sel]=1, capture m_rdata slice sel, go to DONE.
- **DONE**
  - cpu_ready=1 for one cycle with the registered rdata.
  - err=1 if the access was an error.
  - Go to IDLE unconditionally.

Signal rules:
- m_ready and m_rvalid of non-selected slaves are ignored in every state.
- m_rvalid[sel] seen in IDLE or DONE is ignored.
- An error completion returns rdata=0.
- An error write has no effect on any slave.
- m_addr/m_wdata/m_wstrb are stable from REQ entry until return to IDLE.

## Timing
- Reset values: m_avalid=0, m_addr=0, m_wdata=0, m_wstrb=0, cpu_ready=0, cpu_rdata=0, err=0. FSM goes to IDLE.
- Reset mid-transaction aborts immediately: m_avalid drops and no cpu_ready is issued.
- cpu_valid sampled at cycle 0 → m_avalid at cycle 1.
- Minimum latency is 2 cycles: with m_ready and m_rvalid both at cycle 1, cpu_ready is at cycle 2.
- Latency with m_rvalid at cycle k>1 is cpu_ready at cycle k+1.
- Out-of-range decode takes 2 cycles: IDLE → DONE, cpu_ready at cycle 1.
- Back-to-back: if cpu_valid is high in the cycle after DONE, the new request is accepted in that IDLE cycle. Sustained throughput is one access per 3 cycles minimum.
- cpu_rdata holds its last value outside cpu_ready.

## Configuration
- Macro: IOB_NATIVE_BRIDGE_TIMEOUT_EN.
- Defined, timeout behaviour:
  - A TIMEOUT_W-bit counter clears on REQ entry and increments every cycle in REQ/RESP.
  - On reaching 2^TIMEOUT_W-1, the FSM goes to DONE with error. m_avalid drops that cycle.
  - Bit sel of an N_SLAVES-wide dead mask is set.
  - Later accesses to a dead slave go IDLE → DONE with error, without asserting m_avalid.
  - The dead mask clears only on rst.
- Undefined: no counter and no dead mask exist, and the bridge waits indefinitely.

## Test plan
- **Read, slave 1:** N_SLAVES=2, SEL_W=1, cpu_addr=0x8000_0010, m_ready[1]=m_rvalid[1]=1 at cycle 1 with rdata 0xCAFEBABE → cpu_ready at cycle 2, cpu_rdata=0xCAFEBABE, m_avalid=2'b10 only at cycle 1.
- **Write with delayed response:** cpu_wstrb=4'b0011, wdata 0x1234_5678, addr 0x0000_0004; m_ready[0] at cycle 3, m_rvalid[0] at cycle 6 → m_avalid[0] high for cycles 1–3, m_wstrb=0011 stable through cycle 6, cpu_ready at cycle 7, err=0.
- **Instruction override:** I_SLAVE=0, cpu_instr=1, cpu_addr=0x8000_0000 → m_avalid=2'b01. The same access with cpu_instr=0 → m_avalid=2'b10.
- **Out-of-range decode:** N_SLAVES=3, SEL_W=2, addr=0xC000_0000 → no m_avalid, cpu_ready and err at cycle 1, cpu_rdata=0.
- **Timeout (macro on, TIMEOUT_W=4):** slave 1 never answers → err and cpu_ready 15 cycles after REQ entry. A following access to slave 1 completes in 2 cycles with err=1 and m_avalid never set. After rst, access to slave 1 is issued normally.
- **Reset mid-RESP:** rst asserted while in RESP → next cycle all outputs 0, no cpu_ready. After rst release, a new cpu_valid completes normally.
